fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage ahead of the control decoder. Holds the PC and requests words from
//  instruction memory over a req/ready handshake. Latches each returned word into an instruction
//  register and presents it, with its opcode/funct fields, to decode/execute.
//  Next PC is selected from the NPCOp code that the decoder returns.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; address of the first fetch
//  NOP_INSTR 32'h0000_0013  instr value driven while no valid instruction is held (addi x0,x0,0)
// PORTS
//  clk          in   1   single clock; all state on rising edge
//  rstn         in   1   asynchronous, active-low reset
//  npc_op       in   2   00 pc+4, 01 branch taken (pc+imm), 10 jal (pc+imm), 11 jalr ({alu_out[31:1],1'b0})
//  imm          in   32  sign-extended immediate from extender, for the held instr
//  alu_out      in   32  ALU result (rs1+imm), jalr target
//  instr_accept in   1   downstream has executed the held instr; npc_op/imm/alu_out valid this cycle
//  stall        in   1   freeze: no PC update, no new request, no state change
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address (= pc)
//  imem_rdata   in   32  fetched word, valid when imem_ready=1
//  imem_ready   in   1   memory response; completes the request in the same cycle
//  pc           out  32  PC of the held / in-flight instruction
//  pc_plus4     out  32  pc+4, combinational (link value for jal/jalr)
//  instr        out  32  instruction register
//  instr_valid  out  1   instr holds a fetched, not-yet-accepted instruction
//  op           out  7   instr[6:0]
//  funct3       out  3   instr[14:12]
//  funct7       out  7   instr[31:25]
//  misalign     out  1   sticky: a computed next PC had next[1:0]!=0
// BEHAVIOUR
//  Reset (async, rstn=0): pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, misalign=0,
//   state=S_BOOT. Reset asserted mid-handshake aborts it; the memory response is ignored.
//  FSM states: S_BOOT, S_FETCH, S_ISSUE, S_HALT.
//   S_BOOT : first cycle after reset release, nothing driven; -> S_FETCH.
//   S_FETCH: imem_req=1, imem_addr=pc.
//     - req and addr held stable until imem_ready.
//     - imem_ready=1 and stall=0: instr<=imem_rdata, instr_valid<=1, -> S_ISSUE.
//     - imem_ready=1 with stall=1: response discarded; request repeats next cycle.
//   S_ISSUE: imem_req=0; instr/op/funct3/funct7 stable.
//     - instr_accept=1 and stall=0: next PC computed per npc_op, then:
//         pc<=next, instr_valid<=0, instr<=NOP_INSTR, -> S_FETCH.
//     - instr_accept=1 with stall=1: ignored; downstream re-asserts it.
//   S_HALT : imem_req=0, instr_valid=0; left only by reset.
//  Misaligned target: if next[1:0]!=0 on accept (jalr target is aligned to bit 0 first):
//   pc<=next, misalign<=1, -> S_HALT.
//  Arithmetic: 32-bit modulo, no carry out. pc+4 from 32'hFFFF_FFFC wraps to 0; pc+imm wraps likewise.
//  Latency: minimum 2 cycles/instr (FETCH with ready=1, then ISSUE with accept=1). Memory wait
//   states add cycles 1:1.
//  op/funct3/funct7 are pure slices of instr (NOP fields when instr_valid=0).
// TESTING
//  T1 reset: rstn low mid-FETCH -> pc=RESET_PC, req=0, instr=32'h13, valid=0; first req 2 cycles after release.
//  T2 sequential: ready=1 always, accept=1 in ISSUE, npc_op=00 -> imem_addr 0,4,8,C on alternating cycles.
//  T3 wait states: ready low 3 cycles at addr 0x10 -> req/addr held; instr loaded on 4th cycle.
//  T4 branch/jal: pc=0x20, imm=0xFFFF_FFF0, npc_op=01 -> next fetch at 0x10; npc_op=10, imm=0x100 -> 0x120.
//  T5 jalr: alu_out=0x0000_0203, npc_op=11 -> pc=0x202, misalign=1, state S_HALT, req stays 0.
//  T6 stall/wrap: pc=0xFFFF_FFFC, stall=1 with accept=1 -> pc unchanged; stall=0 -> pc=0, no misalign.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
// A request completes in the same cycle that ready is high.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  ready
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from imem, holds it for
// decode until accepted, then moves to the next PC chosen by the decoder's npc_op.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [1:0]         npc_op,
    input  logic [31:0]        imm,
    input  logic [31:0]        alu_out,
    input  logic               instr_accept,
    input  logic               stall,
    fetch_unit_if.master       imem,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [6:0]         op,
    output logic [2:0]         funct3,
    output logic [6:0]         funct7,
    output logic               misalign
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JAL    = 2'b10;
    localparam logic [1:0] NPC_JALR   = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] next_pc;

    // jalr drops bit 0 of the target before the alignment check; all sums wrap mod 2^32.
    function automatic logic [31:0] calc_next_pc(
        input logic [1:0]  sel,
        input logic [31:0] cur_pc,
        input logic [31:0] offset,
        input logic [31:0] jalr_tgt
    );
        logic [31:0] result;
        case (sel)
            NPC_SEQ:    result = cur_pc + 32'd4;
            NPC_BRANCH: result = cur_pc + offset;
            NPC_JAL:    result = cur_pc + offset;
            NPC_JALR:   result = jalr_tgt & 32'hFFFF_FFFE;
            default:    result = cur_pc + 32'd4;
        endcase
        return result;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = misalign_q;
        next_pc       = calc_next_pc(npc_op, pc_q, imm, alu_out);

        case (state_q)
            S_BOOT: begin
                if (!stall) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A response that arrives while stalled is dropped; req stays up so it is re-fetched.
                if (imem.ready && !stall) begin
                    instr_d       = imem.rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_accept && !stall) begin
                    pc_d          = next_pc;
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        state_d    = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                instr_d       = NOP_INSTR;
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign imem.req    = (state_q == S_FETCH);
    assign imem.addr   = pc_q;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;

    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run, all compared
// against a cycle-level behavioural model of the fetch/issue protocol.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int PH_BOOT  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_ISSUE = 2;
    localparam int PH_HALT  = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [1:0]  npc_op = 2'b00;
    logic [31:0] imm = '0;
    logic [31:0] alu_out = '0;
    logic        instr_accept = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc, pc_plus4, instr;
    logic        instr_valid, misalign;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;

    fetch_unit_if imem ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .npc_op      (npc_op),
        .imm         (imm),
        .alu_out     (alu_out),
        .instr_accept(instr_accept),
        .stall       (stall),
        .imem        (imem.master),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_mis;

    task automatic model_reset();
        m_phase = PH_BOOT;
        m_pc    = RESET_PC;
        m_instr = NOP_INSTR;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_clock();
        logic [31:0] tgt;
        if (!rstn) begin
            model_reset();
        end else if (stall) begin
            // frozen
        end else if (m_phase == PH_BOOT) begin
            m_phase = PH_FETCH;
        end else if (m_phase == PH_FETCH) begin
            if (imem.ready) begin
                m_instr = imem.rdata;
                m_valid = 1'b1;
                m_phase = PH_ISSUE;
            end
        end else if (m_phase == PH_ISSUE) begin
            if (instr_accept) begin
                if (npc_op == 2'd0)      tgt = m_pc + 32'd4;
                else if (npc_op == 2'd3) tgt = (alu_out / 2) * 2;
                else                     tgt = m_pc + imm;
                m_pc    = tgt;
                m_valid = 1'b0;
                m_instr = NOP_INSTR;
                if ((tgt % 4) != 0) begin
                    m_mis   = 1'b1;
                    m_phase = PH_HALT;
                end else begin
                    m_phase = PH_FETCH;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_req"},    {31'd0, imem.req},    {31'd0, m_phase == PH_FETCH});
        chk({tag, "_addr"},   imem.addr,            m_pc);
        chk({tag, "_pc"},     pc,                   m_pc);
        chk({tag, "_pc4"},    pc_plus4,             m_pc + 32'd4);
        chk({tag, "_instr"},  instr,                m_instr);
        chk({tag, "_valid"},  {31'd0, instr_valid}, {31'd0, m_valid});
        chk({tag, "_op"},     {25'd0, op},          {25'd0, m_instr[6:0]});
        chk({tag, "_funct3"}, {29'd0, funct3},      {29'd0, m_instr[14:12]});
        chk({tag, "_funct7"}, {25'd0, funct7},      {25'd0, m_instr[31:25]});
        chk({tag, "_mis"},    {31'd0, misalign},    {31'd0, m_mis});
    endtask

    task automatic step(input logic rdy, input logic [31:0] rdata, input logic acc,
                        input logic stl, input logic [1:0] sel, input logic [31:0] im,
                        input logic [31:0] alu, input string tag);
        imem.ready   = rdy;
        imem.rdata   = rdata;
        instr_accept = acc;
        stall        = stl;
        npc_op       = sel;
        imm          = im;
        alu_out      = alu;
        model_clock();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] w;
        logic        r_rdy, r_acc, r_stl;
        logic [1:0]  r_sel;
        logic [31:0] r_imm, r_alu;

        imem.ready = 1'b0;
        imem.rdata = '0;
        model_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_all("t1_por");

        // T1: release, boot cycle, then a fetch interrupted by reset with ready high
        rstn = 1'b1;
        chk("t1_boot_req", {31'd0, imem.req}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t1_fetch");
        chk("t1_first_req", {31'd0, imem.req}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t1_wait");
        imem.ready = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        do_reset("t1_mid");
        chk("t1_mid_pc",    pc,    RESET_PC);
        chk("t1_mid_instr", instr, 32'h0000_0013);
        chk("t1_mid_valid", {31'd0, instr_valid}, 32'd0);
        chk("t1_rel_req",   {31'd0, imem.req},    32'd0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t1_boot2");
        chk("t1_resp_ignored", {31'd0, instr_valid}, 32'd0);

        // T2: sequential fetches at 0,4,8,C
        exp_addr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            chk("t2_addr", imem.addr, exp_addr);
            step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t2_load");
            chk("t2_issue_req", {31'd0, imem.req}, 32'd0);
            step(1'b0, $urandom, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "t2_accept");
            exp_addr = exp_addr + 32'd4;
        end

        // T3: three wait states at 0x10, a stalled response, then the load
        for (int k = 0; k < 3; k++) begin
            step(1'b0, $urandom, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t3_wait");
            chk("t3_req",  {31'd0, imem.req}, 32'd1);
            chk("t3_addr", imem.addr, 32'h10);
        end
        step(1'b1, 32'h1111_1111, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, "t3_stalled");
        chk("t3_discard", {31'd0, instr_valid}, 32'd0);
        w = 32'hFE5A_C2B3;
        step(1'b1, w, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t3_load");
        chk("t3_instr",  instr, w);
        chk("t3_funct7", {25'd0, funct7}, {25'd0, w[31:25]});

        // T4: branch / jal targets
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd1, 32'h10, 32'h0, "t4_to20");
        chk("t4_pc20", pc, 32'h20);
        step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t4_f1");
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd1, 32'hFFFF_FFF0, 32'h0, "t4_br");
        chk("t4_br_addr", imem.addr, 32'h10);
        step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t4_f2");
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0, "t4_back20");
        step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t4_f3");
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, "t4_jal");
        chk("t4_jal_addr", imem.addr, 32'h120);
        step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t4_f4");

        // T6: jalr to the top word (bit 0 dropped), stalled accept, then wrap
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd3, 32'h0, 32'hFFFF_FFFD, "t6_jalr");
        chk("t6_pc_top", pc, 32'hFFFF_FFFC);
        chk("t6_pc4_wrap", pc_plus4, 32'h0);
        step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t6_f");
        step(1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, "t6_stall");
        chk("t6_stall_pc",    pc, 32'hFFFF_FFFC);
        chk("t6_stall_valid", {31'd0, instr_valid}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "t6_wrap");
        chk("t6_wrap_pc",  pc, 32'h0);
        chk("t6_wrap_mis", {31'd0, misalign}, 32'd0);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            if (m_phase == PH_HALT) do_reset("rnd_reset");
            r_rdy = ($urandom_range(0, 3) != 0);
            r_acc = ($urandom_range(0, 2) != 0);
            r_stl = ($urandom_range(0, 7) == 0);
            r_sel = 2'($urandom_range(0, 3));
            r_imm = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) r_imm = $urandom;
            r_alu = $urandom;
            if ($urandom_range(0, 15) != 0) r_alu[1] = 1'b0;
            step(r_rdy, $urandom, r_acc, r_stl, r_sel, r_imm, r_alu, "rnd");
        end

        // T5: misaligned jalr halts the stage
        do_reset("t5_reset");
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t5_boot");
        step(1'b1, $urandom, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "t5_f");
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0000_0203, "t5_jalr");
        chk("t5_pc",  pc, 32'h202);
        chk("t5_mis", {31'd0, misalign}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, $urandom, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "t5_halt");
            chk("t5_halt_req",   {31'd0, imem.req},    32'd0);
            chk("t5_halt_valid", {31'd0, instr_valid}, 32'd0);
        end
        do_reset("t5_clear");
        chk("t5_mis_cleared", {31'd0, misalign}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
